// File: rtl/xb_l_syn.sv
// Low-pass wavelet synthesis: 2x upsampling 8-tap polyphase FIR through one shared MAC; XB_SYN_ROUND_EN selects round-half-up over floor.
// Latency: even output 4 cycles and odd output 8 cycles after accept; no backpressure, strobes while busy are dropped and flagged on overrun.
module xb_l_syn #(
    parameter int NTAP_PH = 4,
    parameter int ACC_W   = 36
) (
    input  logic               clk,
    input  logic               reset,
    input  logic signed [15:0] data_in,
    input  logic               data_in_read,
    input  logic signed [15:0] xbl_reg0,
    input  logic signed [15:0] xbl_reg1,
    input  logic signed [15:0] xbl_reg2,
    input  logic signed [15:0] xbl_reg3,
    input  logic signed [15:0] xbl_reg4,
    input  logic signed [15:0] xbl_reg5,
    input  logic signed [15:0] xbl_reg6,
    input  logic signed [15:0] xbl_reg7,
    output logic signed [15:0] data_out,
    output logic               ready,
    output logic               data_out_phase,
    output logic               busy,
    output logic               overrun
);

    localparam int KW = $clog2(NTAP_PH);
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-32768);

    typedef enum logic [1:0] {IDLE, MAC_E, MAC_O} state_t;

    state_t                  state, state_nxt;
    logic [KW-1:0]           k;
    logic signed [15:0]      xd   [NTAP_PH];
    logic signed [15:0]      coef [2*NTAP_PH];
    logic signed [ACC_W-1:0] acc, acc_sum, acc_rnd, shifted;
    logic signed [31:0]      prod;
    logic signed [15:0]      sat_val;
    logic                    last_tap;
    logic                    odd;

    assign busy     = (state != IDLE);
    assign last_tap = (k == KW'(NTAP_PH - 1));
    assign odd      = (state == MAC_O);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (data_in_read) state_nxt = MAC_E;
            MAC_E:   if (last_tap)     state_nxt = MAC_O;
            MAC_O:   if (last_tap)     state_nxt = IDLE;
            default:                   state_nxt = IDLE;
        endcase
    end

    // Coefficient index is {k, phase}: even phase uses c[2k], odd phase c[2k+1].
    always_comb begin
        prod    = coef[{k, odd}] * xd[k];
        acc_sum = acc + $signed({{(ACC_W-32){prod[31]}}, prod});
`ifdef XB_SYN_ROUND_EN
        acc_rnd = acc_sum + ACC_W'(16384);
`else
        acc_rnd = acc_sum;
`endif
        shifted = acc_rnd >>> 15;
        if (shifted > SAT_MAX)
            sat_val = 16'sh7FFF;
        else if (shifted < SAT_MIN)
            sat_val = -16'sh8000;
        else
            sat_val = shifted[15:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            k              <= '0;
            acc            <= '0;
            data_out       <= '0;
            ready          <= 1'b0;
            data_out_phase <= 1'b0;
            overrun        <= 1'b0;
            for (int i = 0; i < NTAP_PH; i++)   xd[i]   <= '0;
            for (int i = 0; i < 2*NTAP_PH; i++) coef[i] <= '0;
        end else begin
            state   <= state_nxt;
            ready   <= 1'b0;
            overrun <= data_in_read && (state != IDLE);
            case (state)
                IDLE: begin
                    if (data_in_read) begin
                        xd[0] <= data_in;
                        for (int i = 1; i < NTAP_PH; i++) xd[i] <= xd[i-1];
                        // Snapshot taps so register writes mid-sample cannot disturb it.
                        coef[0] <= xbl_reg0;
                        coef[1] <= xbl_reg1;
                        coef[2] <= xbl_reg2;
                        coef[3] <= xbl_reg3;
                        coef[4] <= xbl_reg4;
                        coef[5] <= xbl_reg5;
                        coef[6] <= xbl_reg6;
                        coef[7] <= xbl_reg7;
                        acc     <= '0;
                        k       <= '0;
                    end
                end
                MAC_E, MAC_O: begin
                    if (last_tap) begin
                        data_out       <= sat_val;
                        ready          <= 1'b1;
                        data_out_phase <= odd;
                        acc            <= '0;
                        k              <= '0;
                    end else begin
                        acc <= acc_sum;
                        k   <= k + KW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_xb_l_syn.sv
// Bench for xb_l_syn: directed impulse/saturation/overrun/reset/coefficient cases plus random samples against a sum-of-products model.
module tb_xb_l_syn;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] data_in;
    logic        data_in_read;
    logic [15:0] creg [8];
    logic [15:0] data_out;
    logic        ready, data_out_phase, busy, overrun;

    always #5 clk = ~clk;

    xb_l_syn dut (
        .clk(clk), .reset(reset), .data_in(data_in), .data_in_read(data_in_read),
        .xbl_reg0(creg[0]), .xbl_reg1(creg[1]), .xbl_reg2(creg[2]), .xbl_reg3(creg[3]),
        .xbl_reg4(creg[4]), .xbl_reg5(creg[5]), .xbl_reg6(creg[6]), .xbl_reg7(creg[7]),
        .data_out(data_out), .ready(ready), .data_out_phase(data_out_phase),
        .busy(busy), .overrun(overrun)
    );

    int n_chk = 0;
    int n_err = 0;

    logic signed [15:0] hist [4];
    logic signed [15:0] snap [8];
    logic [15:0]        last_out;
    logic [15:0]        got_e, got_o;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // y = sat(floor(sum c*x / 2^15)), optionally rounded half-up.
    function automatic logic [15:0] ref_out(input int ph);
        longint s = 0;
        for (int j = 0; j < 4; j++)
            s += longint'(snap[2*j+ph]) * longint'(hist[j]);
`ifdef XB_SYN_ROUND_EN
        s += 16384;
`endif
        s = s >>> 15;
        if (s > 32767)  return 16'h7FFF;
        if (s < -32768) return 16'h8000;
        return s[15:0];
    endfunction

    task automatic model_clear();
        for (int j = 0; j < 4; j++) hist[j] = '0;
        last_out = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        data_in_read = 1'b0;
        step();
        step();
        reset = 1'b0;
        model_clear();
    endtask

    task automatic set_taps(input logic [15:0] a0, a1, a2, a3, a4, a5, a6, a7);
        creg[0] = a0; creg[1] = a1; creg[2] = a2; creg[3] = a3;
        creg[4] = a4; creg[5] = a5; creg[6] = a6; creg[7] = a7;
    endtask

    // One full sample from the first IDLE cycle; ovr_at/chg_at name the edge Ei carrying the extra event.
    task automatic run_sample(input logic [15:0] x, input int ovr_at, input int chg_at,
                              input logic [15:0] chg_val, input string tag);
        logic [15:0] exp_e, exp_o;
        for (int j = 3; j > 0; j--) hist[j] = hist[j-1];
        hist[0] = x;
        for (int j = 0; j < 8; j++) snap[j] = creg[j];
        exp_e = ref_out(0);
        exp_o = ref_out(1);
        data_in = x;
        data_in_read = 1'b1;
        step();
        data_in_read = 1'b0;
        for (int i = 0; i <= 8; i++) begin
            if (i == 4) begin last_out = exp_e; got_e = data_out; end
            if (i == 8) begin last_out = exp_o; got_o = data_out; end
            chk({tag, ".ready"},   ready,    (i == 4 || i == 8));
            chk({tag, ".busy"},    busy,     (i < 8));
            chk({tag, ".overrun"}, overrun,  (i == ovr_at));
            chk({tag, ".data"},    data_out, last_out);
            if (i == 4) chk({tag, ".phase_e"}, data_out_phase, 1'b0);
            if (i == 8) chk({tag, ".phase_o"}, data_out_phase, 1'b1);
            if (i < 8) begin
                if (i + 1 == ovr_at) begin
                    data_in = 16'($urandom);
                    data_in_read = 1'b1;
                end
                if (i + 1 == chg_at) creg[0] = chg_val;
                step();
                data_in_read = 1'b0;
            end
        end
    endtask

    task automatic impulse_seq(input int ovr_at, input string tag);
        logic [15:0] exp_pair [8];
        exp_pair = '{16'h0800, 16'h1000, 16'h1800, 16'h2000,
                     16'h2800, 16'h3000, 16'h3800, 16'hC000};
        for (int s = 0; s < 4; s++) begin
            run_sample((s == 0) ? 16'h4000 : 16'h0000, (s == 0) ? ovr_at : -1, -1, 16'h0, tag);
            chk({tag, ".even"}, got_e, exp_pair[2*s]);
            chk({tag, ".odd"},  got_o, exp_pair[2*s+1]);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        data_in = '0;
        data_in_read = 1'b0;
        set_taps(0, 0, 0, 0, 0, 0, 0, 0);
        do_reset();
        chk("rst.data",    data_out,       16'h0);
        chk("rst.ready",   ready,          1'b0);
        chk("rst.phase",   data_out_phase, 1'b0);
        chk("rst.busy",    busy,           1'b0);
        chk("rst.overrun", overrun,        1'b0);

        set_taps(16'h1000, 16'h2000, 16'h3000, 16'h4000, 16'h5000, 16'h6000, 16'h7000, 16'h8000);
        impulse_seq(-1, "imp");

        do_reset();
        impulse_seq(3, "ovr");

        set_taps(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
        do_reset();
        for (int s = 0; s < 4; s++) run_sample(16'h7FFF, -1, -1, 16'h0, "satp");
        chk("satp.even", got_e, 16'h7FFF);
        chk("satp.odd",  got_o, 16'h7FFF);
        do_reset();
        for (int s = 0; s < 4; s++) run_sample(16'h8000, -1, -1, 16'h0, "satn");
        chk("satn.even", got_e, 16'h8000);
        chk("satn.odd",  got_o, 16'h8000);

        set_taps(16'h1000, 16'h2000, 16'h3000, 16'h4000, 16'h5000, 16'h6000, 16'h7000, 16'h8000);
        data_in = 16'h4000;
        data_in_read = 1'b1;
        step();
        data_in_read = 1'b0;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        model_clear();
        chk("mid.data",    data_out,       16'h0);
        chk("mid.phase",   data_out_phase, 1'b0);
        chk("mid.busy",    busy,           1'b0);
        chk("mid.overrun", overrun,        1'b0);
        for (int i = 0; i < 10; i++) begin
            chk("mid.ready", ready, 1'b0);
            step();
        end
        run_sample(16'h4000, -1, -1, 16'h0, "mid_imp");
        chk("mid_imp.even", got_e, 16'h0800);
        chk("mid_imp.odd",  got_o, 16'h1000);

        do_reset();
        run_sample(16'h4000, -1, 1, 16'h7FFF, "coef");
        chk("coef.even", got_e, 16'h0800);
        run_sample(16'h4000, -1, -1, 16'h0, "coef_next");

        do_reset();
        set_taps(16'h4000, 0, 0, 0, 0, 0, 0, 0);
        run_sample(16'h0001, -1, -1, 16'h0, "rnd");

        do_reset();
        for (int s = 0; s < 60; s++) begin
            int ov;
            if ((s % 8) == 0)
                for (int j = 0; j < 8; j++) creg[j] = 16'($urandom);
            ov = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 8)) : -1;
            run_sample(16'($urandom), ov, -1, 16'h0, "rand");
            if ($urandom_range(0, 3) == 0) step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/xb_l_syn.md
Name: xb_l_syn

Overview:
Low-pass wavelet synthesis (reconstruction) channel: the inverse of the even/odd-split low-pass decomposition top.
- Accepts one 16-bit coefficient-domain sample per handshake and upsamples by 2 through an 8-tap polyphase FIR.
- Even phase uses taps 0,2,4,6; odd phase uses taps 1,3,5,7.
- Emits two output samples per input, serially, through one shared MAC.
- Taps come from the same xbl_reg0..7 register bank the decomposition side uses.

Parameters:
- NTAP_PH, 4, taps per polyphase branch (fixed; 2*NTAP_PH coefficients).
- ACC_W, 36, signed accumulator width.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- data_in  input  16  signed Q1.15 input sample.
- data_in_read  input  1  write strobe; one-cycle pulse per sample.
- xbl_reg0..xbl_reg7  input  16 each  signed Q1.15 coefficients c0..c7.
- data_out  output  16  signed Q1.15 reconstructed sample (registered).
- ready  output  1  one-cycle pulse; data_out valid.
- data_out_phase  output  1  0 = even sample y[2n], 1 = odd sample y[2n+1]; valid with ready.
- busy  output  1  high while a sample is being processed.
- overrun  output  1  one-cycle pulse; a strobe was dropped.

Behaviour:
- Single clock domain: clk. Reset is synchronous and active-high.
- Reset values:
  - State IDLE.
  - Delay line x[n..n-3] = 0, latched coefficients = 0, accumulator = 0.
  - data_out = 0, ready = 0, data_out_phase = 0, busy = 0, overrun = 0.
- Reset mid-operation aborts the sequence. No ready is issued for the aborted sample. Delay-line history is cleared.
- FSM states: IDLE, MAC_E, MAC_O.
  - busy = (state != IDLE).
- Accept edge E0 (state IDLE and data_in_read):
  - Shift data_in into x[n]; older samples move down; x[n-3] is discarded.
  - Latch xbl_reg0..7 into internal c0..c7. Later register changes do not affect this sample.
  - Clear the accumulator and the tap index; go to MAC_E.
- MAC_E, edges E1..E4 (tap index k = 0..3): acc += c[2k] * x[n-k].
  - At E4: data_out <= sat(acc_final); ready <= 1; data_out_phase <= 0; acc cleared; go to MAC_O.
- MAC_O, edges E5..E8: acc += c[2k+1] * x[n-k].
  - At E8: data_out <= sat(acc_final); ready <= 1; data_out_phase <= 1; go to IDLE.
- ready is high in exactly the two cycles following E4 and E8. It is 0 otherwise.
- data_out holds its value between pulses.
- Throughput: earliest next accept is E9, i.e. 9 cycles per input sample.
- data_in_read while busy, including on E8 itself:
  - The sample is dropped and the delay line is unchanged.
  - overrun pulses for 1 cycle; the FSM is unaffected.
- Arithmetic:
  - 16x16 signed product gives a 32-bit result, sign-extended to ACC_W.
  - Result = acc >>> 15 (arithmetic shift, i.e. floor).
  - Saturate to [-32768, 32767].

Optional Feature:
- Macro XB_SYN_ROUND_EN.
  - Defined: add 2^14 to acc before the >>>15 (round-half-up), then saturate.
  - Undefined: plain floor truncation as above.
- Check case: x = 0x0001, c0 = 0x4000 → even output 0x0001 with the macro, 0x0000 without.

Test Plan:
1. Impulse response.
   - Setup: c0..c7 = 0x1000,0x2000,0x3000,0x4000,0x5000,0x6000,0x7000,0x8000.
   - Stimulus: x = 0x4000, then three samples of 0x0000, each strobed once IDLE.
   - Required outputs, as even/odd pairs:
     - 0x0800 / 0x1000
     - 0x1800 / 0x2000
     - 0x2800 / 0x3000
     - 0x3800 / 0xC000
2. Timing.
   - Strobe at E0 → busy high for 8 cycles.
   - ready pulses in the cycles after E4 and E8 only, with data_out_phase 0 then 1.
   - A strobe in the first IDLE cycle after E8 is accepted.
3. Saturation.
   - Positive: all coeffs 0x7FFF, four inputs of 0x7FFF → 4th sample's even and odd outputs = 0x7FFF.
   - Negative: all coeffs 0x7FFF, four inputs of 0x8000 → 4th sample's outputs = 0x8000.
4. Overrun.
   - Strobe at E0+3 during test 1 → overrun pulses once.
   - Output sequence is identical to test 1; no extra ready.
5. Reset mid-op.
   - Assert reset for 1 cycle at E2 → no ready; all outputs 0.
   - A following impulse reproduces 0x0800 / 0x1000 with no residual history.
6. Coefficient change.
   - Write xbl_reg0 = 0x7FFF at E1 of an impulse → even output still 0x0800.
   - The next accepted sample uses 0x7FFF.
